// File: rtl/soft_i2c_slave_ahb.sv
// I2C target terminating the soft-I2C AHB-bridge protocol: 16-byte register window plus AHB request pulses.
// Build option SOFT_I2C_SLAVE_GLITCH_FILTER_EN inserts a 3-sample majority filter on SCL/SDA.
//
// state     | meaning
// IDLE      | ignore bus until START (also the hold after NACK or a foreign address)
// ADDR      | shift in 7-bit address + R/W
// ADDR_ACK  | drive address ACK
// REG       | shift in register pointer
// REG_ACK   | drive pointer ACK
// WDATA     | shift in write byte
// WDATA_ACK | drive write-byte ACK
// RDATA     | shift out reg[pointer]
// RDATA_ACK | sample master ACK/NACK
module soft_i2c_slave_ahb #(
  parameter logic [6:0]  DEV_ADDR = 7'h66,
  parameter int unsigned REG_AW   = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_o,
  output logic        sda_oe_o,
  output logic [31:0] ahb_waddr_o,
  output logic [31:0] ahb_wdata_o,
  output logic [31:0] ahb_raddr_o,
  output logic        ahb_wr_req_o,
  output logic        ahb_rd_req_o,
  input  logic [31:0] ahb_rdata_i,
  input  logic        ahb_rdata_vld_i,
  output logic        busy_o
);
  localparam int unsigned       NREG     = 2 ** REG_AW;
  localparam logic [REG_AW-1:0] WREQ_IDX = REG_AW'(7);
  localparam logic [REG_AW-1:0] RREQ_IDX = REG_AW'(11);
  localparam logic [REG_AW-1:0] RO_BASE  = REG_AW'(12);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_e;

  logic [1:0] scl_sync, sda_sync;
  logic       scl_c, sda_c;
  logic       scl_q, sda_q;

  // bus idles high, so synchronizers reset to 1 to avoid a phantom edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
    end
  end

`ifdef SOFT_I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_hist, sda_hist;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_c    <= 1'b1;
      sda_c    <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
      scl_c    <= (scl_sync[1] & scl_hist[0]) | (scl_sync[1] & scl_hist[1]) | (scl_hist[0] & scl_hist[1]);
      sda_c    <= (sda_sync[1] & sda_hist[0]) | (sda_sync[1] & sda_hist[1]) | (sda_hist[0] & sda_hist[1]);
    end
  end
`else
  assign scl_c = scl_sync[1];
  assign sda_c = sda_sync[1];
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_c;
      sda_q <= sda_c;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_c & ~scl_q;
  assign scl_fall  = ~scl_c & scl_q;
  assign start_det = scl_c & scl_q & sda_q & ~sda_c;
  assign stop_det  = scl_c & scl_q & ~sda_q & sda_c;

  state_e            state;
  logic [2:0]        bit_cnt;
  logic              byte_done;
  logic [7:0]        rx, tx;
  logic              rw, mack;
  logic [REG_AW-1:0] ptr;
  logic [7:0]        regs [NREG];
  logic              shifting;

  assign shifting = (state == ADDR) || (state == REG) || (state == WDATA) || (state == RDATA);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      bit_cnt      <= 3'd7;
      byte_done    <= 1'b0;
      rx           <= '0;
      tx           <= '0;
      rw           <= 1'b0;
      mack         <= 1'b0;
      ptr          <= '0;
      sda_oe_o     <= 1'b0;
      busy_o       <= 1'b0;
      ahb_wr_req_o <= 1'b0;
      ahb_rd_req_o <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      ahb_wr_req_o <= 1'b0;
      ahb_rd_req_o <= 1'b0;
      if (start_det) begin
        state     <= ADDR;
        bit_cnt   <= 3'd7;
        byte_done <= 1'b0;
        sda_oe_o  <= 1'b0;
      end else if (stop_det) begin
        state    <= IDLE;
        sda_oe_o <= 1'b0;
        busy_o   <= 1'b0;
      end else begin
        if (scl_rise) begin
          if (shifting && !byte_done) begin
            rx <= {rx[6:0], sda_c};
            if (bit_cnt == 3'd0) byte_done <= 1'b1;
            else                 bit_cnt   <= bit_cnt - 3'd1;
          end
          if (state == RDATA_ACK) mack <= sda_c;
        end
        // the fall after the last data bit is where each byte is acted upon
        if (scl_fall) begin
          case (state)
            ADDR: if (byte_done) begin
              if (rx[7:1] == DEV_ADDR) begin
                sda_oe_o <= 1'b1;
                rw       <= rx[0];
                busy_o   <= 1'b1;
                state    <= ADDR_ACK;
              end else begin
                busy_o <= 1'b0;
                state  <= IDLE;
              end
            end
            ADDR_ACK: begin
              bit_cnt   <= 3'd7;
              byte_done <= 1'b0;
              if (rw) begin
                tx       <= regs[ptr];
                sda_oe_o <= ~regs[ptr][7];
                state    <= RDATA;
              end else begin
                sda_oe_o <= 1'b0;
                state    <= REG;
              end
            end
            REG: if (byte_done) begin
              ptr      <= rx[REG_AW-1:0];
              sda_oe_o <= 1'b1;
              state    <= REG_ACK;
            end
            REG_ACK, WDATA_ACK: begin
              sda_oe_o  <= 1'b0;
              bit_cnt   <= 3'd7;
              byte_done <= 1'b0;
              state     <= WDATA;
            end
            WDATA: if (byte_done) begin
              if (ptr < RO_BASE) regs[ptr] <= rx;
              ahb_wr_req_o <= (ptr == WREQ_IDX);
              ahb_rd_req_o <= (ptr == RREQ_IDX);
              ptr          <= ptr + REG_AW'(1);
              sda_oe_o     <= 1'b1;
              state        <= WDATA_ACK;
            end
            RDATA: begin
              if (byte_done) begin
                sda_oe_o <= 1'b0;
                ptr      <= ptr + REG_AW'(1);
                state    <= RDATA_ACK;
              end else begin
                tx       <= {tx[6:0], 1'b0};
                sda_oe_o <= ~tx[6];
              end
            end
            RDATA_ACK: begin
              if (!mack) begin
                tx        <= regs[ptr];
                sda_oe_o  <= ~regs[ptr][7];
                bit_cnt   <= 3'd7;
                byte_done <= 1'b0;
                state     <= RDATA;
              end else begin
                sda_oe_o <= 1'b0;
                state    <= IDLE;
              end
            end
            default: ;
          endcase
        end
      end
      // read-data window; an in-flight read byte already sits in tx
      if (ahb_rdata_vld_i) begin
        regs[12] <= ahb_rdata_i[31:24];
        regs[13] <= ahb_rdata_i[23:16];
        regs[14] <= ahb_rdata_i[15:8];
        regs[15] <= ahb_rdata_i[7:0];
      end
    end
  end

  assign sda_o       = 1'b0;
  assign ahb_waddr_o = {regs[0], regs[1], regs[2], regs[3]};
  assign ahb_wdata_o = {regs[4], regs[5], regs[6], regs[7]};
  assign ahb_raddr_o = {regs[8], regs[9], regs[10], regs[11]};

endmodule

// File: tb/tb_soft_i2c_slave_ahb.sv
// Bench for soft_i2c_slave_ahb: bit-banged I2C master on an open-drain bus,
// checked against a byte-array model of the register window.
`timescale 1ns/1ps
module tb_soft_i2c_slave_ahb;
  localparam int         Q   = 6;
  localparam logic [6:0] DEV = 7'h66;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        scl_i, sda_i, sda_o, sda_oe_o;
  logic [31:0] ahb_waddr_o, ahb_wdata_o, ahb_raddr_o;
  logic [31:0] ahb_rdata_i = '0;
  logic        ahb_rdata_vld_i = 1'b0;
  logic        ahb_wr_req_o, ahb_rd_req_o, busy_o;

  assign scl_i = scl_m;
  assign sda_i = sda_m & ~sda_oe_o;

  always #5 clk_i = ~clk_i;

  soft_i2c_slave_ahb dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .scl_i           (scl_i),
    .sda_i           (sda_i),
    .sda_o           (sda_o),
    .sda_oe_o        (sda_oe_o),
    .ahb_waddr_o     (ahb_waddr_o),
    .ahb_wdata_o     (ahb_wdata_o),
    .ahb_raddr_o     (ahb_raddr_o),
    .ahb_wr_req_o    (ahb_wr_req_o),
    .ahb_rd_req_o    (ahb_rd_req_o),
    .ahb_rdata_i     (ahb_rdata_i),
    .ahb_rdata_vld_i (ahb_rdata_vld_i),
    .busy_o          (busy_o)
  );

  int         n_pass = 0;
  int         n_total = 0;
  int         wr_pulses = 0;
  int         rd_pulses = 0;
  logic       oe_seen = 1'b0;
  logic       busy_seen = 1'b0;
  logic [7:0] mdl [16];
  int         mptr = 0;
  int         exp_wr = 0;
  int         exp_rd = 0;
  logic [7:0] wq[$];
  logic [7:0] rq[$];
  int         acks = 0;
  logic       busy_mid = 1'b0;
  logic       oe_after_nack = 1'b0;
  logic [31:0] mid_val = '0;

  always @(negedge clk_i) begin
    if (ahb_wr_req_o) wr_pulses++;
    if (ahb_rd_req_o) rd_pulses++;
    if (sda_oe_o)     oe_seen = 1'b1;
    if (busy_o)       busy_seen = 1'b1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "time limit");
  end

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    mptr = 0;
  endfunction

  function automatic void model_write(input int r);
    int p = r;
    foreach (wq[i]) begin
      if (p < 12) mdl[p] = wq[i];
      if (p == 7)  exp_wr++;
      if (p == 11) exp_rd++;
      p = (p + 1) % 16;
    end
    mptr = p;
  endfunction

  function automatic void model_load(input logic [31:0] v);
    mdl[12] = v[31:24];
    mdl[13] = v[23:16];
    mdl[14] = v[15:8];
    mdl[15] = v[7:0];
  endfunction

  // ---------------- bus master ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    b = sda_i; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic put_byte(input logic [7:0] d, output logic acked);
    logic a;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(a);
    acked = ~a;
  endtask

  task automatic get_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(nack);
  endtask

  task automatic send_addr_reg(input int r);
    logic a;
    i2c_start();
    put_byte({DEV, 1'b0}, a); acks += int'(a);
    busy_mid = busy_o;
    put_byte(8'(r), a); acks += int'(a);
  endtask

  task automatic write_txn(input int r);
    logic a;
    acks = 0;
    send_addr_reg(r);
    foreach (wq[i]) begin
      put_byte(wq[i], a);
      acks += int'(a);
    end
    i2c_stop();
    model_write(r);
  endtask

  task automatic get_bytes(input int n);
    logic [7:0] d;
    rq.delete();
    for (int i = 0; i < n; i++) begin
      get_byte(d, (i == n - 1));
      rq.push_back(d);
    end
    tick(Q);
    oe_after_nack = sda_oe_o;
  endtask

  task automatic read_txn(input int r, input int n, input logic mid_vld);
    logic a;
    acks = 0;
    send_addr_reg(r);
    wq.delete();
    model_write(r);
    i2c_rstart();
    put_byte({DEV, 1'b1}, a); acks += int'(a);
    if (mid_vld) begin
      fork
        begin
          tick(12 * Q);
          ahb_rdata_i = mid_val;
          ahb_rdata_vld_i = 1'b1;
          tick(1);
          ahb_rdata_vld_i = 1'b0;
        end
      join_none
    end
    get_bytes(n);
    i2c_stop();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] got [8];
    string       nm  [8];
    nm = '{"sda_o", "sda_oe", "waddr", "wdata", "raddr", "wr_req", "rd_req", "busy"};
    rst_ni = 1'b0;
    tick(3);
    for (int ph = 0; ph < 2; ph++) begin
      got[0] = 32'(sda_o);  got[1] = 32'(sda_oe_o);
      got[2] = ahb_waddr_o; got[3] = ahb_wdata_o; got[4] = ahb_raddr_o;
      got[5] = 32'(ahb_wr_req_o); got[6] = 32'(ahb_rd_req_o); got[7] = 32'(busy_o);
      for (int i = 0; i < 8; i++) begin
        n_total++;
        if (got[i] !== 32'h0) $display("FAIL reset_%s phase%0d: got %h required 0", nm[i], ph, got[i]);
        else n_pass++;
      end
      rst_ni = 1'b1;
      tick(5);
    end
    model_reset();
  endtask

  task automatic test_write_basic();
    int w0 = wr_pulses, r0 = rd_pulses;
    wq = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    write_txn(0);
    n_total++; if (acks !== 10) $display("FAIL wb_acks: got %0d required 10", acks); else n_pass++;
    n_total++; if (ahb_waddr_o !== 32'h12345678) $display("FAIL wb_waddr: got %h required 12345678", ahb_waddr_o); else n_pass++;
    n_total++; if (ahb_wdata_o !== 32'hAABBCCDD) $display("FAIL wb_wdata: got %h required aabbccdd", ahb_wdata_o); else n_pass++;
    n_total++; if (wr_pulses - w0 !== 1) $display("FAIL wb_wr_pulses: got %0d required 1", wr_pulses - w0); else n_pass++;
    n_total++; if (rd_pulses - r0 !== 0) $display("FAIL wb_rd_pulses: got %0d required 0", rd_pulses - r0); else n_pass++;
    n_total++; if (busy_mid !== 1'b1) $display("FAIL wb_busy_mid: got %b required 1", busy_mid); else n_pass++;
    n_total++; if (busy_o !== 1'b0) $display("FAIL wb_busy_after_stop: got %b required 0", busy_o); else n_pass++;
  endtask

  task automatic test_raddr();
    int w0 = wr_pulses, r0 = rd_pulses;
    wq = '{8'h00, 8'h00, 8'h10, 8'h00};
    write_txn(8);
    n_total++; if (acks !== 6) $display("FAIL ra_acks: got %0d required 6", acks); else n_pass++;
    n_total++; if (ahb_raddr_o !== 32'h00001000) $display("FAIL ra_raddr: got %h required 00001000", ahb_raddr_o); else n_pass++;
    n_total++; if (rd_pulses - r0 !== 1) $display("FAIL ra_rd_pulses: got %0d required 1", rd_pulses - r0); else n_pass++;
    n_total++; if (wr_pulses - w0 !== 0) $display("FAIL ra_wr_pulses: got %0d required 0", wr_pulses - w0); else n_pass++;
  endtask

  task automatic test_read();
    logic [31:0] got;
    tick(1);
    ahb_rdata_i = 32'hDEADBEEF; ahb_rdata_vld_i = 1'b1; tick(1); ahb_rdata_vld_i = 1'b0;
    model_load(32'hDEADBEEF);
    read_txn(12, 4, 1'b0);
    got = {rq[0], rq[1], rq[2], rq[3]};
    n_total++; if (acks !== 3) $display("FAIL rd_acks: got %0d required 3", acks); else n_pass++;
    n_total++; if (got !== 32'hDEADBEEF) $display("FAIL rd_data: got %h required deadbeef", got); else n_pass++;
    n_total++; if (oe_after_nack !== 1'b0) $display("FAIL rd_release_after_nack: got %b required 0", oe_after_nack); else n_pass++;
    n_total++; if (busy_o !== 1'b0) $display("FAIL rd_busy_after_stop: got %b required 0", busy_o); else n_pass++;
    mptr = (12 + 4) % 16;
  endtask

  task automatic test_rdata_midflight();
    ahb_rdata_i = 32'h11223344; ahb_rdata_vld_i = 1'b1; tick(1); ahb_rdata_vld_i = 1'b0;
    model_load(32'h11223344);
    mid_val = 32'hA1B2C3D4;
    read_txn(12, 3, 1'b1);
    n_total++; if (rq[0] !== mdl[12]) $display("FAIL mid_byte0: got %h required %h", rq[0], mdl[12]); else n_pass++;
    model_load(32'hA1B2C3D4);
    n_total++; if (rq[1] !== mdl[13]) $display("FAIL mid_byte1: got %h required %h", rq[1], mdl[13]); else n_pass++;
    n_total++; if (rq[2] !== mdl[14]) $display("FAIL mid_byte2: got %h required %h", rq[2], mdl[14]); else n_pass++;
    mptr = (12 + 3) % 16;
  endtask

  task automatic test_bad_addr();
    logic        a0, a1;
    logic [31:0] wa = ahb_waddr_o, ra = ahb_raddr_o;
    int          w0 = wr_pulses;
    oe_seen = 1'b0; busy_seen = 1'b0;
    i2c_start();
    put_byte({7'h55, 1'b0}, a0);
    put_byte(8'h00, a1);
    put_byte(8'h99, a1);
    i2c_stop();
    n_total++; if (a0 !== 1'b0) $display("FAIL bad_addr_ack: got %b required 0", a0); else n_pass++;
    n_total++; if (oe_seen !== 1'b0) $display("FAIL bad_addr_sda_driven: got %b required 0", oe_seen); else n_pass++;
    n_total++; if (busy_seen !== 1'b0) $display("FAIL bad_addr_busy: got %b required 0", busy_seen); else n_pass++;
    n_total++; if (ahb_waddr_o !== wa) $display("FAIL bad_addr_waddr: got %h required %h", ahb_waddr_o, wa); else n_pass++;
    n_total++; if (ahb_raddr_o !== ra) $display("FAIL bad_addr_raddr: got %h required %h", ahb_raddr_o, ra); else n_pass++;
    n_total++; if (wr_pulses !== w0) $display("FAIL bad_addr_wr_pulse: got %0d required %0d", wr_pulses, w0); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_wa;
    logic [7:0]  keep3 = mdl[3];
    logic        a;
    wq.delete();
    for (int i = 0; i < 5; i++) wq.push_back(8'($urandom_range(0, 255)));
    exp_wa = {wq[2], wq[3], wq[4], keep3};
    write_txn(14);
    n_total++; if (acks !== 7) $display("FAIL wrap_acks: got %0d required 7", acks); else n_pass++;
    n_total++; if (ahb_waddr_o !== exp_wa) $display("FAIL wrap_waddr: got %h required %h", ahb_waddr_o, exp_wa); else n_pass++;
    // pointer kept across STOP: a bare read continues at the wrapped position
    i2c_start();
    put_byte({DEV, 1'b1}, a);
    get_bytes(1);
    i2c_stop();
    n_total++; if (rq[0] !== mdl[mptr]) $display("FAIL wrap_ptr_retained: got %h required %h", rq[0], mdl[mptr]); else n_pass++;
    mptr = (mptr + 1) % 16;
    read_txn(12, 4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (rq[i] !== mdl[12 + i]) $display("FAIL wrap_ro_reg%0d: got %h required %h", 12 + i, rq[i], mdl[12 + i]);
      else n_pass++;
    end
    mptr = 0;
  endtask

  task automatic test_reset_mid();
    logic a;
    i2c_start();
    put_byte({DEV, 1'b0}, a);
    put_byte(8'h00, a);
    put_bit(1'b1);
    put_bit(1'b0);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q / 2);
    rst_ni = 1'b0;
    #1;
    n_total++; if (sda_oe_o !== 1'b0) $display("FAIL rstmid_sda_oe: got %b required 0", sda_oe_o); else n_pass++;
    n_total++; if (busy_o !== 1'b0) $display("FAIL rstmid_busy: got %b required 0", busy_o); else n_pass++;
    n_total++; if (ahb_waddr_o !== 32'h0) $display("FAIL rstmid_waddr: got %h required 0", ahb_waddr_o); else n_pass++;
    n_total++; if (ahb_raddr_o !== 32'h0) $display("FAIL rstmid_raddr: got %h required 0", ahb_raddr_o); else n_pass++;
    tick(4);
    sda_m = 1'b1; scl_m = 1'b1;
    rst_ni = 1'b1;
    tick(2 * Q);
    model_reset();
    wq = '{8'hC3, 8'h5A, 8'h0F, 8'hE1};
    write_txn(0);
    n_total++; if (acks !== 6) $display("FAIL rstmid_next_acks: got %0d required 6", acks); else n_pass++;
    n_total++; if (ahb_waddr_o !== 32'hC35A0FE1) $display("FAIL rstmid_next_waddr: got %h required c35a0fe1", ahb_waddr_o); else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      int w0 = wr_pulses, r0 = rd_pulses, ew0 = exp_wr, er0 = exp_rd;
      int r = $urandom_range(0, 15);
      int n = $urandom_range(1, 5);
      int rr, rn;
      if ($urandom_range(0, 1) == 1) begin
        logic [31:0] v = $urandom;
        ahb_rdata_i = v; ahb_rdata_vld_i = 1'b1; tick(1); ahb_rdata_vld_i = 1'b0;
        model_load(v);
      end
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back(8'($urandom_range(0, 255)));
      write_txn(r);
      n_total++; if (acks !== n + 2) $display("FAIL rnd%0d_acks: got %0d required %0d", it, acks, n + 2); else n_pass++;
      n_total++; if (wr_pulses - w0 !== exp_wr - ew0) $display("FAIL rnd%0d_wr_pulses: got %0d required %0d", it, wr_pulses - w0, exp_wr - ew0); else n_pass++;
      n_total++; if (rd_pulses - r0 !== exp_rd - er0) $display("FAIL rnd%0d_rd_pulses: got %0d required %0d", it, rd_pulses - r0, exp_rd - er0); else n_pass++;
      rr = $urandom_range(0, 15);
      rn = $urandom_range(1, 4);
      read_txn(rr, rn, 1'b0);
      for (int i = 0; i < rn; i++) begin
        n_total++;
        if (rq[i] !== mdl[(rr + i) % 16]) $display("FAIL rnd%0d_rd%0d: got %h required %h", it, i, rq[i], mdl[(rr + i) % 16]);
        else n_pass++;
      end
      mptr = (rr + rn) % 16;
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_raddr();
    test_read();
    test_rdata_midflight();
    test_bad_addr();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/soft_i2c_slave_ahb.md
Name: soft_i2c_slave_ahb

Overview:
- I2C target that terminates the soft I2C master's AHB-bridge protocol.
- Decodes START/addr/reg-pointer/data sequences on SCL/SDA, oversampled on clk_i.
- Holds a 16-byte register window (waddr, wdata, raddr, rdata) and raises single-cycle AHB-side request pulses.
- Sits on the slave/FPGA side, driving the AHB master that serves the remote bridge.

Parameters:
- DEV_ADDR, 7'h66, 7-bit I2C device address this target acknowledges.
- REG_AW, 4, register pointer width; window is 2**REG_AW bytes, fixed map below.

Ports:
- clk_i  in  1  system clock, at least 16x SCL rate.
- rst_ni  in  1  asynchronous active-low reset.
- scl_i  in  1  I2C clock from pad, asynchronous.
- sda_i  in  1  I2C data from pad, asynchronous.
- sda_o  out  1  data to pad; always 0 (open-drain emulation).
- sda_oe_o  out  1  1 = pull SDA low; 0 = release.
- ahb_waddr_o  out  32  regs 0x00..0x03, big-endian (0x00 = [31:24]).
- ahb_wdata_o  out  32  regs 0x04..0x07, big-endian.
- ahb_raddr_o  out  32  regs 0x08..0x0B, big-endian.
- ahb_wr_req_o  out  1  one-cycle pulse: write request.
- ahb_rd_req_o  out  1  one-cycle pulse: read request.
- ahb_rdata_i  in  32  read data returned by the AHB side.
- ahb_rdata_vld_i  in  1  loads ahb_rdata_i into regs 0x0C..0x0F.
- busy_o  out  1  high from a START that matched DEV_ADDR until STOP.

Behaviour:
- Clock and reset: single clock domain clk_i; rst_ni is asynchronous and active-low.
- Reset values: sda_o=0, sda_oe_o=0, all 32-bit outputs 0, both req pulses 0, busy_o=0, pointer 0, FSM IDLE.
- Input sync: scl_i and sda_i each pass a 2-FF synchronizer. Edges are detected from the previous synced value.
- START: synced SDA falls while SCL high. Accepted in any state (repeated START); FSM goes to ADDR, bit counter = 7.
- STOP: synced SDA rises while SCL high. FSM goes to IDLE, sda_oe_o=0, busy_o=0. Pointer is retained.
- Sampling: data bits sampled on SCL rising edge. SDA changes (ACK drive, read data) only on SCL falling edge, applied the cycle after the edge is detected.
- FSM states: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- ADDR: shift 8 bits MSB first. On the falling edge after bit 0:
  - if addr[7:1]==DEV_ADDR, drive ACK (sda_oe_o=1) and go to ADDR_ACK;
  - else go to IDLE (ignore until next START).
- ADDR_ACK: release SDA on the next falling edge. R/W=0 goes to REG. R/W=1 goes to RDATA and drives bit 7 of reg[pointer] on that same edge (sda_oe_o = ~bit).
- REG: 8 bits received; pointer <= byte[REG_AW-1:0]; ACK; then WDATA.
- WDATA: byte received is written to reg[pointer], then ACK.
  - 0x0C..0x0F are read-only: ACKed, write discarded.
  - Pointer increments after every byte, wrapping 0x0F -> 0x00.
- ahb_wr_req_o: pulses the cycle after a byte lands at 0x07.
- ahb_rd_req_o: pulses the cycle after a byte lands at 0x0B. It must not fire for writes to 0x08..0x0A.
- RDATA: shift out reg[pointer] MSB first. Pointer increments when the byte completes. In RDATA_ACK the master's bit is sampled on SCL rise:
  - 0 (ACK): continue with the next byte;
  - 1 (NACK): release SDA, wait in IDLE-like hold until STOP/START.
- ahb_rdata_vld_i: loads regs 0x0C..0x0F on any cycle. If it coincides with a byte being shifted out, the in-flight byte is unaffected (shift register already loaded); later bytes see the new value.
- Simultaneous request pulses: impossible by construction (one byte per ACK).
- Reset mid-transfer: everything returns to reset values immediately; SDA is released.

Optional Feature:
- Macro: SOFT_I2C_SLAVE_GLITCH_FILTER_EN.
- Defined: after the synchronizer, scl and sda each pass a 3-sample majority filter, suppressing pulses of 1 clk_i cycle. Edge-to-action latency grows from 3 to 5 clk_i cycles.
- Undefined: no filter; latency is 3 cycles from pad edge to FSM action.

Test Plan:
- Write 0x66<<1|0, reg 0x00, then bytes 12 34 56 78 AA BB CC DD -> ahb_waddr_o=0x12345678, ahb_wdata_o=0xAABBCCDD, exactly one ahb_wr_req_o pulse after the 8th byte, all 10 bytes ACKed.
- Write reg 0x08, then 00 00 10 00 -> ahb_raddr_o=0x00001000, one ahb_rd_req_o pulse, ahb_wr_req_o stays 0.
- ahb_rdata_vld_i with 0xDEADBEEF; write reg 0x0C, repeated START, read 4 bytes, ACK ACK ACK NACK, STOP -> master reads DE AD BE EF; SDA released after NACK.
- Address 0x55 write -> no ACK (SDA stays released); registers unchanged; busy_o stays 0.
- Write reg 0x0E, then 5 bytes -> 0x0E/0x0F writes discarded, pointer wraps, bytes 3..5 land at 0x00..0x02; all ACKed.
- rst_ni low during the 3rd data bit of a write -> sda_oe_o=0 immediately; outputs 0; the next full transaction completes normally.
